vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/clk_en_div.sv | 34 +++
 rtl/vga_sync_gen.sv | 95 +++++++++
 tb/tb_vga_sync_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the pixel-counter type used by the sync
// generator and the display grid. Default timing is 640x480@60.
package vga_timing_pkg;

  localparam int COUNT_W = 10;
  typedef logic [COUNT_W-1:0] count_t;

  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_DISP_START = 144;
  localparam int DEF_H_DISP_END   = 783;
  localparam int DEF_V_TOTAL      = 525;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_DISP_START = 35;
  localparam int DEF_V_DISP_END   = 514;

  // Top-left corner of the visible window, in counter coordinates.
  localparam count_t DISP_ORIGIN_X = count_t'(DEF_H_DISP_START);
  localparam count_t DISP_ORIGIN_Y = count_t'(DEF_V_DISP_START);
  localparam int     DISP_WIDTH    = DEF_H_DISP_END - DEF_H_DISP_START + 1;
  localparam int     DISP_HEIGHT   = DEF_V_DISP_END - DEF_V_DISP_START + 1;

  function automatic logic in_window(input count_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: pix_en is high for one clk out of every CLK_DIV.
// With CLK_DIV == 1 the enable is tied high and no counter exists.
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  generate
    if (CLK_DIV <= 1) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, rst_n};
      assign pix_en        = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      logic [DW-1:0] div_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_cnt <= '0;
        end else if (pix_en) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      assign pix_en = (div_cnt == DW'(CLK_DIV - 1));
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel counters, sync pulses, visible-window flag and
// frame/line markers. Define VGA_FRAME_CNT_EN to add a 16-bit frame counter.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV      = DEF_CLK_DIV,
  parameter int   H_TOTAL      = DEF_H_TOTAL,
  parameter int   H_SYNC       = DEF_H_SYNC,
  parameter int   H_DISP_START = DEF_H_DISP_START,
  parameter int   H_DISP_END   = DEF_H_DISP_END,
  parameter int   V_TOTAL      = DEF_V_TOTAL,
  parameter int   V_SYNC       = DEF_V_SYNC,
  parameter int   V_DISP_START = DEF_V_DISP_START,
  parameter int   V_DISP_END   = DEF_V_DISP_END,
  parameter logic SYNC_ACTIVE  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         pix_en,
  output logic [9:0]   hCount,
  output logic [9:0]   vCount,
  output logic         bright,
  output logic         hSync,
  output logic         vSync,
  output logic         frame_start,
  output logic         line_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]  frame_cnt
`endif
);

  count_t h_next;
  count_t v_next;
  logic   frame_wrap;

  clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  always_comb begin
    h_next     = hCount;
    v_next     = vCount;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (hCount == count_t'(H_TOTAL - 1)) begin
        h_next = '0;
        if (vCount == count_t'(V_TOTAL - 1)) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = vCount + 1'b1;
        end
      end else begin
        h_next = hCount + 1'b1;
      end
    end
  end

  // Decode from the next counts so syncs and bright move on the same edge
  // as the counters themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCount      <= '0;
      vCount      <= '0;
      bright      <= 1'b0;
      hSync       <= SYNC_ACTIVE;
      vSync       <= SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      hCount      <= h_next;
      vCount      <= v_next;
      bright      <= in_window(h_next, H_DISP_START, H_DISP_END) &&
                     in_window(v_next, V_DISP_START, V_DISP_END);
      hSync       <= (int'(h_next) < H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vSync       <= (int'(v_next) < V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start <= frame_wrap;
    end
  end

  assign line_end = pix_en && (hCount == count_t'(H_TOTAL - 1));

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a full-size instance, a shrunken-timing
// instance (inverted sync polarity) and an undivided CLK_DIV=1 instance.
module tb_vga_sync_gen;

  logic clk;
  logic rst_n;

  logic       pe_a, br_a, hs_a, vs_a, fs_a, le_a;
  logic [9:0] h_a, v_a;
  logic       pe_b, br_b, hs_b, vs_b, fs_b, le_b;
  logic [9:0] h_b, v_b;
  logic       pe_c, br_c, hs_c, vs_c, fs_c, le_c;
  logic [9:0] h_c, v_c;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  typedef struct {
    int   tick;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic br;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_tests = 0;
  int n_fail  = 0;
  int fs_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_a), .hCount(h_a), .vCount(v_a),
    .bright(br_a), .hSync(hs_a), .vSync(vs_a), .frame_start(fs_a), .line_end(le_a)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  // Shrunken raster: 20x12 pixels, window 5..16 x 3..9, active-low syncs.
  vga_sync_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(16),
    .V_TOTAL(12), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(9), .SYNC_ACTIVE(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_b), .hCount(h_b), .vCount(v_b),
    .bright(br_b), .hSync(hs_b), .vSync(vs_b), .frame_start(fs_b), .line_end(le_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(16),
    .V_TOTAL(12), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(9), .SYNC_ACTIVE(1'b1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_c), .hCount(h_c), .vCount(v_c),
    .bright(br_c), .hSync(hs_c), .vSync(vs_c), .frame_start(fs_c), .line_end(le_c)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_c)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input bit sel_b, input int t, input int h, input int v,
                      input logic hs, input logic vs, input logic br);
    exp_t e;
    e = '{tick: t, h: h, v: v, hs: hs, vs: vs, br: br};
    if (sel_b) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                     input logic hs, input logic vs, input logic br);
    $display("[SB] %s tick %0d: h=%0d v=%0d hs=%0b vs=%0b br=%0b", tag, e.tick, h, v, hs, vs, br);
    check($sformatf("%s_t%0d_h", tag, e.tick),  32'(h),  32'(e.h));
    check($sformatf("%s_t%0d_v", tag, e.tick),  32'(v),  32'(e.v));
    check($sformatf("%s_t%0d_hs", tag, e.tick), 32'(hs), 32'(e.hs));
    check($sformatf("%s_t%0d_vs", tag, e.tick), 32'(vs), 32'(e.vs));
    check($sformatf("%s_t%0d_br", tag, e.tick), 32'(br), 32'(e.br));
  endtask

  // Pixel ticks are counted per pix_en edge; an entry is compared on its tick.
  initial begin : mon_a
    int   tick;
    logic pe;
    exp_t e;
    tick = 0;
    forever begin
      @(negedge clk); pe = pe_a;
      @(posedge clk); #1;
      if (!rst_n) tick = 0;
      else if (pe) begin
        tick++;
        if (q_a.size() > 0 && q_a[0].tick == tick) begin
          e = q_a.pop_front();
          cmp("a", e, h_a, v_a, hs_a, vs_a, br_a);
        end
      end
    end
  end

  initial begin : mon_b
    int   tick;
    logic pe;
    exp_t e;
    tick = 0;
    forever begin
      @(negedge clk); pe = pe_b;
      @(posedge clk); #1;
      if (!rst_n) tick = 0;
      else if (pe) begin
        tick++;
        if (q_b.size() > 0 && q_b[0].tick == tick) begin
          e = q_b.pop_front();
          cmp("b", e, h_b, v_b, hs_b, vs_b, br_b);
        end
      end
    end
  end

  // Frame-level checks on dut_b: 480 clk per frame, 84 bright pixels, 12 lines.
  initial begin : mon_frame
    int   cyc, last_fs, br_cnt, le_cnt;
    bit   counting;
    logic fs_prev;
    cyc = 0; last_fs = 0; br_cnt = 0; le_cnt = 0; counting = 0; fs_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        cyc = 0; last_fs = 0; br_cnt = 0; le_cnt = 0; counting = 0; fs_prev = 1'b0;
        fs_cnt = 0;
      end else begin
        cyc++;
        if (fs_b) begin
          check("fs_pos_h", 32'(h_b), 32'd0);
          check("fs_pos_v", 32'(v_b), 32'd0);
          check("fs_width", 32'(fs_prev), 32'd0);
          check("fs_period", 32'(cyc - last_fs), 32'd480);
          if (counting) begin
            check("bright_per_frame", 32'(br_cnt), 32'd84);
            check("line_end_per_frame", 32'(le_cnt), 32'd12);
          end
          fs_cnt++;
`ifdef VGA_FRAME_CNT_EN
          check("frame_cnt", 32'(fc_b), 32'(fs_cnt));
`endif
          $display("[FRAME] b frame_start #%0d at cycle %0d, bright=%0d lines=%0d",
                   fs_cnt, cyc, br_cnt, le_cnt);
          last_fs = cyc; counting = 1; br_cnt = 0; le_cnt = 0;
        end
        if (pe_b && br_b) br_cnt++;
        if (le_b) begin
          le_cnt++;
          check("line_end_h", 32'(h_b), 32'd19);
          check("line_end_pe", 32'(pe_b), 32'd1);
        end
        fs_prev = fs_b;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_pe_a"}, 32'(pe_a), 32'd0);
    check({tag, "_h_a"},  32'(h_a),  32'd0);
    check({tag, "_v_a"},  32'(v_a),  32'd0);
    check({tag, "_br_a"}, 32'(br_a), 32'd0);
    check({tag, "_hs_a"}, 32'(hs_a), 32'd1);
    check({tag, "_vs_a"}, 32'(vs_a), 32'd1);
    check({tag, "_fs_a"}, 32'(fs_a), 32'd0);
    check({tag, "_pe_b"}, 32'(pe_b), 32'd0);
    check({tag, "_h_b"},  32'(h_b),  32'd0);
    check({tag, "_v_b"},  32'(v_b),  32'd0);
    check({tag, "_hs_b"}, 32'(hs_b), 32'd0);
    check({tag, "_vs_b"}, 32'(vs_b), 32'd0);
    check({tag, "_fs_b"}, 32'(fs_b), 32'd0);
    check({tag, "_h_c"},  32'(h_c),  32'd0);
  endtask

  task automatic push_vectors(input bit full);
    // Full-size raster: hs = h<96, vs = v<2, window never reached by v<=2.
    push(0, 1, 1, 0, 1, 1, 0);
    push(0, 95, 95, 0, 1, 1, 0);
    push(0, 96, 96, 0, 0, 1, 0);
    if (full) begin
      push(0, 144, 144, 0, 0, 1, 0);
      push(0, 799, 799, 0, 0, 1, 0);
      push(0, 800, 0, 1, 1, 1, 0);
      push(0, 1600, 0, 2, 1, 0, 0);
      push(0, 1695, 95, 2, 1, 0, 0);
      push(0, 1696, 96, 2, 0, 0, 0);
    end
    // Small raster: tick t -> (t%20, t/20), syncs active-low.
    push(1, 1, 1, 0, 0, 0, 0);
    push(1, 2, 2, 0, 0, 0, 0);
    push(1, 3, 3, 0, 1, 0, 0);
    push(1, 19, 19, 0, 1, 0, 0);
    push(1, 20, 0, 1, 0, 0, 0);
    push(1, 40, 0, 2, 0, 1, 0);
    push(1, 45, 5, 2, 1, 1, 0);
    push(1, 64, 4, 3, 1, 1, 0);
    push(1, 65, 5, 3, 1, 1, 1);
    push(1, 196, 16, 9, 1, 1, 1);
    push(1, 197, 17, 9, 1, 1, 0);
    push(1, 205, 5, 10, 1, 1, 0);
    push(1, 219, 19, 10, 1, 1, 0);
    push(1, 220, 0, 11, 0, 1, 0);
    push(1, 239, 19, 11, 1, 1, 0);
    push(1, 240, 0, 0, 0, 0, 0);
    push(1, 241, 1, 0, 0, 0, 0);
  endtask

  // Release reset and check the divider phase and the undivided counter.
  task automatic release_and_check(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check({tag, "_pe_a_cyc1"}, 32'(pe_a), 32'd0);
    check({tag, "_h_c_cyc1"},  32'(h_c),  32'd1);
    @(posedge clk); #1;
    check({tag, "_pe_a_cyc2"}, 32'(pe_a), 32'd0);
    check({tag, "_h_c_cyc2"},  32'(h_c),  32'd2);
    @(posedge clk); #1;
    check({tag, "_pe_a_cyc3"}, 32'(pe_a), 32'd1);
    check({tag, "_h_c_cyc3"},  32'(h_c),  32'd3);
    @(posedge clk); #1;
    check({tag, "_pe_a_cyc4"}, 32'(pe_a), 32'd0);
    check({tag, "_h_c_cyc4"},  32'(h_c),  32'd4);
  endtask

  task automatic wait_drain(input string tag, input int need_fs);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || fs_cnt < need_fs) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_drain_done"},
          32'((q_a.size() == 0 && q_b.size() == 0 && fs_cnt >= need_fs) ? 1 : 0), 32'd1);
  endtask

  initial begin : stim
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    push_vectors(1'b1);
    release_and_check("run1");
    wait_drain("run1", 3);

    // Drop reset mid-divider: pix_en was high, then two more clk edges.
    n = 0;
    @(posedge clk); #1;
    while (!pe_a && n < 8) begin @(posedge clk); #1; n++; end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_hold");
    push_vectors(1'b0);
    release_and_check("run2");
    wait_drain("run2", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
